inject_scheduler: RTL
=====================

Name: inject_scheduler

Overview:
- Shares the six router injection ports (xpos, ypos, zpos, xneg, yneg, zneg) among NUM_REQ local traffic sources inside the local unit.
- Each source presents one flit plus a 3-bit direction code.
- Each port has its own round-robin arbiter. A port stays locked to one source until that source's packet tail is accepted.
- The port is gated by the router's inject_*_avail, and each output is registered (one flit per cycle per port).

Parameters:
- FLIT_SIZE, 256: flit width in bits; matches the router flit width.
- NUM_REQ, 4: number of requesting sources; legal range 2..8.
- DROP_CNT_W, 16: width of the invalid-direction drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_flit  in  NUM_REQ*FLIT_SIZE  flit from source i, at bits [i*FLIT_SIZE +: FLIT_SIZE]
- req_dir  in  NUM_REQ*3  target port of source i: 0=xpos 1=ypos 2=zpos 3=xneg 4=yneg 5=zneg; 6 and 7 are invalid
- req_last  in  NUM_REQ  flit is the tail of its packet (single-flit packet: last=1)
- req_valid  in  NUM_REQ  source i presents a flit
- req_ready  out  NUM_REQ  flit of source i is consumed this cycle (combinational)
- inject_flit  out  6*FLIT_SIZE  registered flit to port d, at bits [d*FLIT_SIZE +: FLIT_SIZE]
- inject_valid  out  6  registered valid, one bit per port
- inject_avail  in  6  router can accept an injection on port d this cycle
- drop_cnt  out  DROP_CNT_W  saturating count of flits dropped for an invalid direction

Behaviour:
- Reset, applied at a clk edge with rst=1:
  - inject_valid=0, inject_flit=0, drop_cnt=0.
  - All per-port pointers=0 and all ports return to IDLE; any lock is released.
  - req_ready=0 while rst=1.
  - A flit granted in the cycle rst rises is lost: it is not presented on inject_valid.
- Candidate set per port d: sources i with req_valid[i]=1 and req_dir[i]==d. Each source targets one port, so a source receives at most one grant per cycle.
- Per-port FSM, IDLE state:
  - If inject_avail[d]=1 and candidates exist, grant the first candidate at or after ptr[d], searching cyclically.
  - If the granted flit has req_last=0, go to LOCKED(owner=winner).
  - If req_last=1, stay IDLE.
  - In both cases ptr[d] <= (winner+1) mod NUM_REQ; wrap from NUM_REQ-1 to 0.
- Per-port FSM, LOCKED(owner) state:
  - Only owner is eligible; all other candidates are held off with req_ready=0.
  - Grant when req_valid[owner]=1, req_dir[owner]==d and inject_avail[d]=1.
  - On a grant with req_last=1, return to IDLE; ptr[d] is not changed by the tail.
  - An owner bubble (req_valid low) keeps the port LOCKED with no output.
  - If owner changes req_dir while locked, it is not granted on the other port until that port is free. A lock is never broken except by rst.
- Grant handshake: req_ready[i]=1 in the same cycle as the grant.
  - Next cycle: inject_flit[d] <= granted flit and inject_valid[d] <= 1.
  - Latency from req to inject is 1 cycle.
  - No grant on port d means inject_valid[d]=0 next cycle; inject_flit[d] holds its last value.
- inject_avail[d]=0 means no grant on port d and req_ready=0 for all its candidates. FSM state and ptr[d] hold.
- Invalid direction (6 or 7) with req_valid=1:
  - req_ready=1 that cycle and the flit is discarded.
  - drop_cnt increments by the number of such sources that cycle, saturating at 2^DROP_CNT_W-1.
  - The flit is never locked onto a port.
- All six ports arbitrate independently and in parallel; up to 6 flits are accepted per cycle.
- req_ready depends combinationally on req_valid, req_dir and inject_avail. Sources must not make req_valid depend on req_ready.

Test Plan:
- Reset: after rst, inject_valid=000000 and drop_cnt=0. With rst held high and all requests valid, req_ready stays 0.
- Round-robin: NUM_REQ=4; sources 0..3 all valid, dir=0, last=1, avail=all 1, for 8 cycles. inject_valid[0] is high from cycle 1; granted sources follow 0,1,2,3,0,1,2,3.
- Packet lock:
  - Stimulus: source 1 sends 3 flits to dir 2 (last on the 3rd) with a one-cycle bubble after flit 1; source 2 valid to dir 2 throughout.
  - Required response: source 2 is not granted until the cycle after source 1's tail is accepted. Output order is S1f0, S1f1, S1f2, then S2.
- Backpressure: avail[4]=0 for 5 cycles with source 0 valid to dir 4. req_ready[0]=0 throughout; the flit is granted the cycle avail rises and appears on inject port 4 one cycle later.
- Parallel and invalid:
  - Stimulus: sources 0..3 with dir 0,3,5,7, all valid and last=1, for 1 cycle.
  - Required response: req_ready=1111; next cycle inject_valid=101001 (bit 5 set, then bits 3 and 0) and drop_cnt=1.
- Saturation and mid-packet reset:
  - Force drop_cnt to 0xFFFF via 65535+ invalid flits; it stays at 0xFFFF.
  - Assert rst while port 1 is LOCKED. After reset, a different source is granted port 1 immediately.

Source files
------------

// File: rtl/inject_scheduler.sv
// rtl/inject_scheduler.sv - shares six router injection ports among NUM_REQ sources
// Per-port round-robin arbiters with packet locking, registered outputs, invalid-direction drop counter.
module inject_scheduler #(
  parameter int FLIT_SIZE  = 256,
  parameter int NUM_REQ    = 4,
  parameter int DROP_CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*FLIT_SIZE-1:0] req_flit,
  input  logic [NUM_REQ*3-1:0]         req_dir,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [6*FLIT_SIZE-1:0]       inject_flit,
  output logic [5:0]                   inject_valid,
  input  logic [5:0]                   inject_avail,
  output logic [DROP_CNT_W-1:0]        drop_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0] NREQ_X = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [DROP_CNT_W+3:0] DROP_MAX = {4'b0, {DROP_CNT_W{1'b1}}};

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e                 state_q [6];
  state_e                 state_d [6];
  logic [IDX_W-1:0]       owner_q [6];
  logic [IDX_W-1:0]       owner_d [6];
  logic [IDX_W-1:0]       ptr_q   [6];
  logic [IDX_W-1:0]       ptr_d   [6];
  logic [IDX_W-1:0]       win     [6];
  logic [5:0]             fire;
  logic [5:0][NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0]     drop_req;

  logic [6*FLIT_SIZE-1:0] inject_flit_q, inject_flit_d;
  logic [5:0]             inject_valid_q;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_W+3:0]  drop_sum;
  logic [3:0]             n_drop;

  // Candidate masks per port, and sources whose direction code is 6 or 7.
  always_comb begin
    cand     = '0;
    drop_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      drop_req[i] = req_valid[i] && (req_dir[i*3 +: 2] == 2'b11 ? 1'b0 : 1'b0);
      drop_req[i] = req_valid[i] && (req_dir[i*3+1 +: 2] == 2'b11);
      for (int d = 0; d < 6; d++) begin
        cand[d][i] = req_valid[i] && (req_dir[i*3 +: 3] == 3'(d));
      end
    end
  end

  always_comb begin
    logic [IDX_W:0] scan_idx;
    scan_idx = '0;
    for (int d = 0; d < 6; d++) begin
      fire[d]    = 1'b0;
      win[d]     = '0;
      state_d[d] = state_q[d];
      owner_d[d] = owner_q[d];
      ptr_d[d]   = ptr_q[d];
      if (inject_avail[d]) begin
        if (state_q[d] == ST_LOCKED) begin
          if (cand[d][owner_q[d]]) begin
            fire[d] = 1'b1;
            win[d]  = owner_q[d];
          end
        end else begin
          // First candidate at or after ptr, searching cyclically.
          for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr_q[d]} + (IDX_W+1)'(k);
            if (scan_idx >= NREQ_X) scan_idx = scan_idx - NREQ_X;
            if (!fire[d] && cand[d][scan_idx[IDX_W-1:0]]) begin
              fire[d] = 1'b1;
              win[d]  = scan_idx[IDX_W-1:0];
            end
          end
        end
      end
      if (fire[d]) begin
        if (state_q[d] == ST_IDLE) begin
          ptr_d[d]   = (win[d] == LAST_IDX) ? '0 : win[d] + 1'b1;
          owner_d[d] = win[d];
          state_d[d] = req_last[win[d]] ? ST_IDLE : ST_LOCKED;
        end else if (req_last[win[d]]) begin
          state_d[d] = ST_IDLE;
        end
      end
    end
  end

  always_comb begin
    req_ready     = '0;
    inject_flit_d = inject_flit_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = drop_req[i];
      for (int d = 0; d < 6; d++) begin
        if (fire[d] && win[d] == IDX_W'(i)) begin
          req_ready[i] = 1'b1;
          inject_flit_d[d*FLIT_SIZE +: FLIT_SIZE] = req_flit[i*FLIT_SIZE +: FLIT_SIZE];
        end
      end
    end
    if (rst) req_ready = '0;
  end

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n_drop = n_drop + 4'(drop_req[i]);
    end
    drop_sum   = {4'b0, drop_cnt_q} + (DROP_CNT_W+4)'(n_drop);
    drop_cnt_d = (drop_sum > DROP_MAX) ? {DROP_CNT_W{1'b1}} : drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inject_flit_q  <= '0;
      inject_valid_q <= '0;
      drop_cnt_q     <= '0;
      for (int d = 0; d < 6; d++) begin
        state_q[d] <= ST_IDLE;
        owner_q[d] <= '0;
        ptr_q[d]   <= '0;
      end
    end else begin
      inject_flit_q  <= inject_flit_d;
      inject_valid_q <= fire;
      drop_cnt_q     <= drop_cnt_d;
      for (int d = 0; d < 6; d++) begin
        state_q[d] <= state_d[d];
        owner_q[d] <= owner_d[d];
        ptr_q[d]   <= ptr_d[d];
      end
    end
  end

  assign inject_flit  = inject_flit_q;
  assign inject_valid = inject_valid_q;
  assign drop_cnt     = drop_cnt_q;

endmodule
